// File: rtl/conv_window_gen.sv
// conv_window_gen: sliding KxK window generator over an AXI4-S packed-pixel stream.
// Clock axi_clk; asynchronous active-low reset axi_reset_n.
// cfg_start/cfg_width/cfg_height start a frame; busy stays high until the final window handshake.
// s_axis_* carries PPB = S_WIDTH/DATA_WIDTH pixels per beat (lane 0 first).
// s_axis_keep is ignored; s_axis_last is advisory.
// m_axis_window element r*K+c holds line r (0 = oldest) and column c (0 = leftmost).
// m_axis_last marks the final window of the frame.
// Optional build macro CONV_WIN_STATUS_EN adds two outputs:
//   err_last      - sticky flag for a misplaced s_axis_last
//   frame_windows - count of window handshakes in the current frame
module conv_window_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int MAX_WIDTH   = 1920,
  parameter int S_WIDTH     = 32
) (
  input  logic                                         axi_clk,
  input  logic                                         axi_reset_n,
  input  logic                                         cfg_start,
  input  logic [15:0]                                  cfg_width,
  input  logic [15:0]                                  cfg_height,
  output logic                                         busy,
  input  logic                                         s_axis_valid,
  input  logic [S_WIDTH-1:0]                           s_axis_data,
  input  logic [S_WIDTH/8-1:0]                         s_axis_keep,
  input  logic                                         s_axis_last,
  output logic                                         s_axis_ready,
  output logic                                         m_axis_valid,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] m_axis_window,
  input  logic                                         m_axis_ready,
  output logic                                         m_axis_last
`ifdef CONV_WIN_STATUS_EN
  ,
  output logic                                         err_last,
  output logic [31:0]                                  frame_windows
`endif
);
  localparam int K   = KERNEL_SIZE;
  localparam int DW  = DATA_WIDTH;
  localparam int PPB = S_WIDTH / DATA_WIDTH;
  localparam int NB  = K - 1;
  localparam int SW  = NB > 1 ? $clog2(NB) : 1;
  localparam int LW  = PPB > 1 ? $clog2(PPB) : 1;
  localparam int AW  = MAX_WIDTH > 1 ? $clog2(MAX_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t st, st_nx;
  logic [15:0] w, h, col, row;
  logic [31:0] tot, in_pix;
  logic [SW-1:0] slot, s1_slot;
  logic [S_WIDTH-1:0] ubuf;
  logic [LW-1:0] lane;
  logic u_valid, adv, p_fire, s_fire, start_ok, last_pix, last_lane;
  logic s1_valid, s1_emit, s1_last;
  logic [DW-1:0] s1_pix;
  logic [DW-1:0] mem [NB][MAX_WIDTH];
  logic [DW-1:0] rd [NB];
  logic [DW-1:0] colv [K];
  logic [DW-1:0] win [K][K];
  logic unused;

  assign unused = ^{s_axis_keep, s_axis_last};
  assign start_ok = st == IDLE && cfg_start && cfg_width >= 16'(K) && 32'(cfg_width) <= MAX_WIDTH &&
                    (32'(cfg_width) % PPB) == 0 && cfg_height >= 16'(K);
  assign adv = !m_axis_valid || m_axis_ready;
  assign last_lane = lane == LW'(PPB - 1);
  assign p_fire = st == RUN && u_valid && adv;
  // A new beat may land in the same cycle the last lane of the current one is consumed.
  assign s_axis_ready = st == RUN && in_pix < tot && (!u_valid || (last_lane && adv));
  assign s_fire = s_axis_valid && s_axis_ready;
  assign last_pix = col == w - 16'd1 && row == h - 16'd1;
  assign busy = st != IDLE;

  always_comb begin
    st_nx = start_ok ? RUN :
            (st == RUN && p_fire && last_pix) ? FLUSH :
            (st == FLUSH && m_axis_valid && m_axis_ready && m_axis_last) ? IDLE : st;
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      st <= IDLE;
      w <= '0;
      h <= '0;
      tot <= '0;
      in_pix <= '0;
      col <= '0;
      row <= '0;
      slot <= '0;
      ubuf <= '0;
      lane <= '0;
      u_valid <= 1'b0;
      s1_valid <= 1'b0;
      s1_emit <= 1'b0;
      s1_last <= 1'b0;
      s1_pix <= '0;
      s1_slot <= '0;
    end else begin
      st <= st_nx;
      if (start_ok) begin
        w <= cfg_width;
        h <= cfg_height;
        tot <= 32'(cfg_width) * 32'(cfg_height);
        in_pix <= '0;
        col <= '0;
        row <= '0;
        slot <= '0;
        u_valid <= 1'b0;
      end
      if (s_fire) begin
        ubuf <= s_axis_data;
        lane <= '0;
        u_valid <= 1'b1;
        in_pix <= in_pix + 32'(PPB);
      end else if (p_fire) begin
        ubuf <= ubuf >> DW;
        lane <= lane + 1'b1;
        u_valid <= !last_lane;
      end
      if (p_fire) begin
        col <= col == w - 16'd1 ? '0 : col + 16'd1;
        if (col == w - 16'd1) begin
          row <= row + 16'd1;
          slot <= slot == SW'(NB - 1) ? '0 : slot + 1'b1;
        end
      end
      if (adv) begin
        s1_valid <= p_fire;
        s1_pix <= ubuf[DW-1:0];
        s1_slot <= slot;
        s1_emit <= col >= 16'(K - 1) && row >= 16'(K - 1);
        s1_last <= last_pix;
      end
    end
  end

  // Read-first line buffers: the slot being overwritten returns the oldest line this cycle.
  always_ff @(posedge axi_clk) begin
    if (p_fire) begin
      for (int i = 0; i < NB; i++) begin
        rd[i] <= mem[i][col[AW-1:0]];
        if (slot == SW'(i)) mem[i][col[AW-1:0]] <= ubuf[DW-1:0];
      end
    end
  end

  // Oldest line sits in the slot just written (slot), then successive slots in rotation.
  always_comb begin
    colv[K-1] = s1_pix;
    for (int r = 0; r < K - 1; r++) colv[r] = rd[SW'((32'(s1_slot) + r) % NB)];
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      m_axis_valid <= 1'b0;
      m_axis_last <= 1'b0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= '0;
    end else if (adv) begin
      m_axis_valid <= s1_valid && s1_emit;
      m_axis_last <= s1_valid && s1_emit && s1_last;
      if (s1_valid) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
          win[r][K-1] <= colv[r];
        end
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign m_axis_window[(r*K+c)*DW +: DW] = win[r][c];
    end
  end

`ifdef CONV_WIN_STATUS_EN
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      err_last <= 1'b0;
      frame_windows <= '0;
    end else if (start_ok) begin
      err_last <= 1'b0;
      frame_windows <= '0;
    end else begin
      if (s_fire && (s_axis_last != (in_pix + 32'(PPB) == tot))) err_last <= 1'b1;
      if (m_axis_valid && m_axis_ready) frame_windows <= frame_windows + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: random and directed frames checked against a window model built from the image.
module tb_conv_window_gen;
  localparam int K = 3, DW = 8, S = 32, PPB = S / DW;
  logic axi_clk = 1'b0;
  logic axi_reset_n = 1'b0;
  logic cfg_start = 1'b0;
  logic [15:0] cfg_width = '0;
  logic [15:0] cfg_height = '0;
  logic busy, s_axis_ready, m_axis_valid, m_axis_last;
  logic s_axis_valid = 1'b0;
  logic s_axis_last = 1'b0;
  logic m_axis_ready = 1'b1;
  logic [S-1:0] s_axis_data = '0;
  logic [K*K*DW-1:0] m_axis_window;
`ifdef CONV_WIN_STATUS_EN
  logic err_last;
  logic [31:0] frame_windows;
`endif
  int checks = 0, errors = 0;
  logic [K*K*DW-1:0] exp_win [$];
  logic exp_last [$];

  conv_window_gen #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .MAX_WIDTH(64), .S_WIDTH(S)) dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .cfg_start(cfg_start), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .busy(busy), .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data),
    .s_axis_keep(4'hF), .s_axis_last(s_axis_last), .s_axis_ready(s_axis_ready),
    .m_axis_valid(m_axis_valid), .m_axis_window(m_axis_window), .m_axis_ready(m_axis_ready),
    .m_axis_last(m_axis_last)
`ifdef CONV_WIN_STATUS_EN
    , .err_last(err_last), .frame_windows(frame_windows)
`endif
  );

  always #5 axi_clk = ~axi_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input int w, input int h, input int mode, input bit ramp,
                           input int abort_n, input int bad_beat, input bit restart);
    logic [DW-1:0] pix [];
    int nb, lim;
    bit stop;
    nb = w * h / PPB;
    pix = new[w * h];
    stop = 1'b0;
    foreach (pix[i]) pix[i] = ramp ? DW'(i) : DW'($urandom);
    exp_win.delete();
    exp_last.delete();
    for (int r = K - 1; r < h; r++)
      for (int c = K - 1; c < w; c++) begin
        logic [K*K*DW-1:0] v;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++) v[(i*K+j)*DW +: DW] = pix[(r-K+1+i)*w + c-K+1+j];
        exp_win.push_back(v);
        exp_last.push_back(r == h - 1 && c == w - 1);
      end
    lim = abort_n > 0 ? abort_n : exp_win.size();
    @(negedge axi_clk);
    cfg_width = 16'(w);
    cfg_height = 16'(h);
    cfg_start = 1'b1;
    @(negedge axi_clk);
    cfg_start = 1'b0;
    check("busy_start", 128'(busy), 128'(1));
    fork
      begin
        int b = 0, t = 0;
        while (b < nb && !stop && t < 5000) begin
          @(negedge axi_clk);
          #1;
          t++;
          if (mode != 0 && $urandom_range(0, 3) == 0) s_axis_valid = 1'b0;
          else begin
            for (int l = 0; l < PPB; l++) s_axis_data[l*DW +: DW] = pix[b*PPB + l];
            s_axis_last = (b == nb - 1) != (b == bad_beat);
            s_axis_valid = 1'b1;
            if (s_axis_ready) b++;
          end
        end
        @(posedge axi_clk);
        #1;
        s_axis_valid = 1'b0;
      end
      begin
        int got = 0, cyc = 0;
        logic hold = 1'b0;
        logic [K*K*DW:0] hv = '0;
        while (got < lim && cyc < 5000) begin
          @(negedge axi_clk);
          cyc++;
          if (hold) check("stall_hold", 128'({m_axis_valid, m_axis_last, m_axis_window}), 128'({1'b1, hv}));
          m_axis_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 1) : 1'($urandom_range(0, 1));
          if (restart && cyc == 6) begin
            cfg_width = 16'd12;
            cfg_start = 1'b1;
          end else cfg_start = 1'b0;
          if (m_axis_valid && m_axis_ready) begin
            check("window", 128'(m_axis_window), 128'(exp_win[got]));
            check("last", 128'(m_axis_last), 128'(exp_last[got]));
            got++;
          end
          hold = m_axis_valid && !m_axis_ready;
          hv = {m_axis_last, m_axis_window};
        end
        if (got < lim) check("window_timeout", 128'(got), 128'(lim));
        stop = 1'b1;
      end
    join
    cfg_start = 1'b0;
    if (abort_n == 0) begin
      @(negedge axi_clk);
      check("busy_end", 128'(busy), 128'(0));
      check("valid_end", 128'(m_axis_valid), 128'(0));
      s_axis_valid = 1'b1;
      #1;
      check("idle_ready", 128'(s_axis_ready), 128'(0));
      s_axis_valid = 1'b0;
`ifdef CONV_WIN_STATUS_EN
      check("frame_windows", 128'(frame_windows), 128'(exp_win.size()));
      check("err_last", 128'(err_last), 128'(bad_beat >= 0));
`endif
    end
  endtask

  initial begin
    int bw [4] = '{2, 10, 8, 68};
    int bh [4] = '{4, 4, 2, 4};
    repeat (3) @(negedge axi_clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_sready", 128'(s_axis_ready), 128'(0));
    check("rst_mvalid", 128'(m_axis_valid), 128'(0));
    check("rst_mlast", 128'(m_axis_last), 128'(0));
    check("rst_window", 128'(m_axis_window), 128'(0));
    axi_reset_n = 1'b1;
    run_frame(8, 4, 0, 1'b1, 0, -1, 1'b0);
    run_frame(8, 4, 1, 1'b1, 0, -1, 1'b0);
    run_frame(16, 6, 2, 1'b0, 0, -1, 1'b1);
    run_frame(16, 6, 0, 1'b1, 0, -1, 1'b0);
    for (int i = 0; i < 4; i++) run_frame(4 * int'($urandom_range(1, 6)), int'($urandom_range(3, 7)), 2, 1'b0, 0, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge axi_clk);
      cfg_width = 16'(bw[i]);
      cfg_height = 16'(bh[i]);
      cfg_start = 1'b1;
      @(negedge axi_clk);
      cfg_start = 1'b0;
      s_axis_valid = 1'b1;
      repeat (2) @(negedge axi_clk);
      check("bad_start_busy", 128'(busy), 128'(0));
      check("bad_start_ready", 128'(s_axis_ready), 128'(0));
      s_axis_valid = 1'b0;
    end
    run_frame(8, 4, 0, 1'b1, 3, -1, 1'b0);
    @(negedge axi_clk);
    axi_reset_n = 1'b0;
    #1;
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_sready", 128'(s_axis_ready), 128'(0));
    check("midrst_mvalid", 128'(m_axis_valid), 128'(0));
    check("midrst_mlast", 128'(m_axis_last), 128'(0));
    check("midrst_window", 128'(m_axis_window), 128'(0));
    repeat (2) @(negedge axi_clk);
    axi_reset_n = 1'b1;
    run_frame(8, 4, 2, 1'b1, 0, -1, 1'b0);
`ifdef CONV_WIN_STATUS_EN
    run_frame(8, 4, 0, 1'b1, 0, 3, 1'b0);
    run_frame(8, 4, 0, 1'b1, 0, -1, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
